s2cif_call_arb: RTL and testbench
=================================

Name: s2cif_call_arb

Overview:
- Round-robin arbiter that shares one scenario-to-circuit call channel (pull/push calls to scenario-side functions) among NREQ driver requesters.
- Each driver posts one call descriptor: function index, address, write data, pull/push.
- The arbiter serialises descriptors onto a single call port toward the s2cif bridge, waits for the return code and read data, then routes the response back to the originating requester.
- Sits between per-channel drivers and the single s2cif bridge instance.

Parameters:
- NREQ, 4, number of requesters (2..16)
- DW, 32, call data width
- AW, 32, call address width
- TO_CYCLES, 1024, WAIT-state timeout limit (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester call request
- req_ready  out  NREQ  one-hot acceptance pulse
- req_push  in  NREQ  1 = push call, 0 = pull call
- req_func  in  NREQ*8  function index per requester
- req_addr  in  NREQ*AW  address per requester
- req_wdata  in  NREQ*DW  push data per requester
- rsp_valid  out  NREQ  one-hot response pulse
- rsp_ret  out  32  signed return code (shared)
- rsp_rdata  out  DW  pull data (shared)
- call_valid  out  1  call issued to bridge
- call_ready  in  1  bridge accepts call
- call_id  out  8  granted requester index
- call_push, call_func, call_addr, call_wdata  out  1/8/AW/DW  latched descriptor
- ret_valid  in  1  bridge return strobe
- ret_code  in  32  signed return code
- ret_rdata  in  DW  returned data
- busy  out  1  FSM not IDLE
- err_proto  out  1  sticky: ret_valid outside WAIT
- err_timeout  out  1  sticky timeout flag (0 when feature is off)

Behaviour:
- Reset: FSM=IDLE; all outputs 0; descriptor registers 0; last_grant=NREQ-1, so requester 0 wins first.
- IDLE:
  - If any req_valid is set, grant the first set bit scanning from last_grant+1 with wrap.
  - Latch that requester's push/func/addr/wdata; pulse req_ready[g] for exactly one cycle; go ISSUE.
  - Requesters must hold fields stable while req_valid=1 and deassert req_valid after req_ready.
- ISSUE:
  - call_valid=1 with the latched descriptor, one cycle after acceptance.
  - On call_valid&call_ready, go WAIT; otherwise hold with a stable descriptor.
- WAIT: on ret_valid, latch ret_code and ret_rdata; go RESP. ret_rdata is latched for push calls too.
- RESP:
  - rsp_valid[g]=1 for one cycle; rsp_ret/rsp_rdata are valid in that cycle and hold until the next RESP.
  - last_grant=g; go IDLE.
  - No acceptance occurs in RESP, so back-to-back calls are spaced at least 4 cycles apart.
- Return code is passed through unmodified: 0 = ok, <0 = data end, >0 = error.
- ret_valid in IDLE/ISSUE/RESP is ignored and sets err_proto.
- Requests arriving during busy wait; fairness guarantees each requester a grant within NREQ transactions.
- Reset mid-operation aborts the transaction immediately: no rsp_valid pulse, call_valid drops asynchronously, and the bridge is responsible for discarding the pending call.
- Sticky flags clear only on rst.

Optional Feature:
- Macro S2CIF_ARB_TIMEOUT_EN.
- Defined:
  - A 32-bit counter runs in WAIT and clears on state entry.
  - When it reaches TO_CYCLES without ret_valid, go RESP with rsp_ret=32'h8000_0000 and rsp_rdata=0, and set err_timeout.
  - A late ret_valid then sets err_proto.
- Undefined: no counter; WAIT waits indefinitely; err_timeout is tied to 0.

Test Plan:
- Reset, then req_valid[2]=1 (pull, func=0, addr=0) with call_ready=1 and ret_valid two cycles later (ret_code=0, rdata=1) -> req_ready[2] pulses at cycle 1, call_valid at cycle 2 with call_id=2, rsp_valid[2] with rsp_ret=0 and rsp_rdata=1.
- All four req_valid held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3; no requester is granted twice consecutively.
- call_ready held low 5 cycles while req 1 pushes wdata=32'h1 -> call_valid stays high and descriptor stays stable for 5 cycles; one call is accepted.
- ret_code=-1 for req 0, then ret_code=3 for req 1 -> rsp_ret=-1 then 3, routed to the correct rsp_valid bits.
- rst asserted in WAIT, then ret_valid strobed -> outputs 0 immediately, no rsp_valid, err_proto=1 after reset release; the next request is granted to requester 0.
- With S2CIF_ARB_TIMEOUT_EN and TO_CYCLES=16, no ret_valid -> rsp_valid after 16 WAIT cycles, rsp_ret=32'h8000_0000, err_timeout=1.

Source files
------------

// File: rtl/s2cif_call_arb.sv
// s2cif_call_arb: round-robin arbiter serialising requester calls onto one s2cif bridge call port.
// Optional WAIT-state timeout enabled by defining S2CIF_ARB_TIMEOUT_EN.
module s2cif_call_arb #(
    parameter int NREQ      = 4,
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int TO_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_push,
    input  logic [NREQ*8-1:0] req_func,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [31:0]       rsp_ret,
    output logic [DW-1:0]     rsp_rdata,
    output logic              call_valid,
    input  logic              call_ready,
    output logic [7:0]        call_id,
    output logic              call_push,
    output logic [7:0]        call_func,
    output logic [AW-1:0]     call_addr,
    output logic [DW-1:0]     call_wdata,
    input  logic              ret_valid,
    input  logic [31:0]       ret_code,
    input  logic [DW-1:0]     ret_rdata,
    output logic              busy,
    output logic              err_proto,
    output logic              err_timeout
);
    localparam int IW = $clog2(NREQ);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] last_q, last_d, gnt_q, gnt_d, pick;
    logic          hit;
    logic          push_q, push_d;
    logic [7:0]    func_q, func_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [31:0]   ret_q, ret_d;
    logic          err_proto_q, err_proto_d;
`ifdef S2CIF_ARB_TIMEOUT_EN
    logic [31:0]   to_cnt_q, to_cnt_d;
    logic          err_to_q, err_to_d;
`endif

    // Scan downward so the requester closest after last_grant is the one left in pick.
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        for (int i = NREQ; i >= 1; i--) begin
            if (req_valid[(int'(last_q) + i) % NREQ]) begin
                hit  = 1'b1;
                pick = IW'((int'(last_q) + i) % NREQ);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        push_d      = push_q;
        func_d      = func_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ret_d       = ret_q;
        rdata_d     = rdata_q;
        err_proto_d = err_proto_q | (ret_valid && state_q != WAIT);
`ifdef S2CIF_ARB_TIMEOUT_EN
        to_cnt_d    = (state_q == WAIT) ? to_cnt_q + 32'd1 : '0;
        err_to_d    = err_to_q;
`endif
        case (state_q)
            IDLE: if (hit) begin
                state_d = ISSUE;
                gnt_d   = pick;
                push_d  = req_push[pick];
                func_d  = req_func[int'(pick)*8 +: 8];
                addr_d  = req_addr[int'(pick)*AW +: AW];
                wdata_d = req_wdata[int'(pick)*DW +: DW];
            end
            ISSUE: state_d = call_ready ? WAIT : ISSUE;
            WAIT: begin
                if (ret_valid) begin
                    state_d = RESP;
                    ret_d   = ret_code;
                    rdata_d = ret_rdata;
                end
`ifdef S2CIF_ARB_TIMEOUT_EN
                else if (to_cnt_q == 32'(TO_CYCLES - 1)) begin
                    state_d  = RESP;
                    ret_d    = 32'h8000_0000;
                    rdata_d  = '0;
                    err_to_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                last_d  = gnt_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= IW'(NREQ - 1);
            gnt_q       <= '0;
            push_q      <= 1'b0;
            func_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ret_q       <= '0;
            rdata_q     <= '0;
            err_proto_q <= 1'b0;
`ifdef S2CIF_ARB_TIMEOUT_EN
            to_cnt_q    <= '0;
            err_to_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            push_q      <= push_d;
            func_q      <= func_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ret_q       <= ret_d;
            rdata_q     <= rdata_d;
            err_proto_q <= err_proto_d;
`ifdef S2CIF_ARB_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            err_to_q    <= err_to_d;
`endif
        end
    end

    assign req_ready  = (state_q == IDLE && hit && !rst) ? NREQ'(1) << pick : '0;
    assign rsp_valid  = (state_q == RESP) ? NREQ'(1) << gnt_q : '0;
    assign rsp_ret    = ret_q;
    assign rsp_rdata  = rdata_q;
    assign call_valid = state_q == ISSUE;
    assign call_id    = 8'(gnt_q);
    assign call_push  = push_q;
    assign call_func  = func_q;
    assign call_addr  = addr_q;
    assign call_wdata = wdata_q;
    assign busy       = state_q != IDLE;
    assign err_proto  = err_proto_q;
`ifdef S2CIF_ARB_TIMEOUT_EN
    assign err_timeout = err_to_q;
`else
    assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_s2cif_call_arb.sv
// tb_s2cif_call_arb: directed self-checking bench for s2cif_call_arb.
module tb_s2cif_call_arb;
    localparam int NREQ = 4;
    logic        clk = 1'b0, rst = 1'b1;
    logic [3:0]  req_valid = '0, req_ready, req_push = '0, rsp_valid;
    logic [31:0] req_func = '0;
    logic [127:0] req_addr = '0, req_wdata = '0;
    logic [31:0] rsp_ret, rsp_rdata, call_addr, call_wdata;
    logic        call_valid, call_ready = 1'b1, call_push;
    logic [7:0]  call_id, call_func;
    logic        ret_valid = 1'b0;
    logic [31:0] ret_code = '0, ret_rdata = '0;
    logic        busy, err_proto, err_timeout;
    int n_vec = 0, n_err = 0, n_acc = 0, exp_acc = 0;

    s2cif_call_arb #(.NREQ(4), .DW(32), .AW(32), .TO_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_push(req_push),
        .req_func(req_func), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ret(rsp_ret), .rsp_rdata(rsp_rdata), .call_valid(call_valid), .call_ready(call_ready),
        .call_id(call_id), .call_push(call_push), .call_func(call_func), .call_addr(call_addr),
        .call_wdata(call_wdata), .ret_valid(ret_valid), .ret_code(ret_code), .ret_rdata(ret_rdata),
        .busy(busy), .err_proto(err_proto), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (call_valid && call_ready) n_acc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one call from IDLE (request already posted) through RESP, ending at the next IDLE negedge.
    task automatic txn(input int g, input logic [31:0] code, input logic [31:0] rd);
        #1 chk("req_ready", 64'(req_ready), 64'(4'b1 << g));
        @(negedge clk); #1;
        chk("call_valid", 64'(call_valid), 64'd1);
        chk("call_id", 64'(call_id), 64'(g));
        @(negedge clk);
        ret_valid = 1'b1; ret_code = code; ret_rdata = rd;
        @(negedge clk);
        ret_valid = 1'b0;
        #1 chk("rsp_valid", 64'(rsp_valid), 64'(4'b1 << g));
        chk("rsp_ret", 64'(rsp_ret), 64'(code));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(rd));
        exp_acc++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk); #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_call_valid", 64'(call_valid), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_err", 64'({err_proto, err_timeout}), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        // single pull call from requester 2
        req_valid = 4'b0100;
        txn(2, 32'd0, 32'd1);
        req_valid = '0;
        // reset while waiting for the bridge
        req_valid = 4'b1000;
        #1 chk("rr_after_2", 64'(req_ready), 64'h8);
        @(negedge clk); req_valid = '0;
        @(negedge clk); #1 chk("wait_busy", 64'(busy), 64'd1);
        exp_acc++;
        rst = 1'b1;
        #1 chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_outs", 64'({call_valid, rsp_valid, call_id}), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); ret_valid = 1'b1;
        #1 chk("stray_rsp", 64'(rsp_valid), 64'd0);
        @(negedge clk); ret_valid = 1'b0;
        #1 chk("err_proto", 64'(err_proto), 64'd1);
        chk("stray_busy", 64'(busy), 64'd0);
        // all requesters busy: grants rotate starting at 0
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) txn(k % 4, 32'(k + 16), 32'(k * 3));
        req_valid = '0;
        // bridge stalls a push from requester 1
        call_ready = 1'b0;
        req_valid = 4'b0010; req_push = 4'b0010;
        req_func[15:8] = 8'h5; req_addr[63:32] = 32'h100; req_wdata[63:32] = 32'h1;
        #1 chk("stall_ready", 64'(req_ready), 64'h2);
        @(negedge clk); req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            #1 chk($sformatf("stall_desc%0d", c),
                   {call_valid, call_push, call_func, call_addr[15:0], call_wdata[31:0]},
                   {1'b1, 1'b1, 8'h5, 16'h100, 32'h1});
            @(negedge clk);
        end
        call_ready = 1'b1;
        @(negedge clk);
        #1 chk("stall_wait", 64'({call_valid, busy}), 64'b01);
        exp_acc++;
        ret_valid = 1'b1; ret_code = 32'd0; ret_rdata = 32'h77;
        @(negedge clk); ret_valid = 1'b0;
        #1 chk("stall_rsp", 64'(rsp_valid), 64'h2);
        chk("push_rdata", 64'(rsp_rdata), 64'h77);
        @(negedge clk);
        req_push = '0;
        // signed return codes routed back
        req_valid = 4'b0001;
        txn(0, 32'hFFFF_FFFF, 32'hAAAA);
        req_valid = 4'b0010;
        txn(1, 32'd3, 32'h5555);
        req_valid = '0;
        chk("hold_ret", 64'(rsp_ret), 64'd3);
        chk("err_proto_sticky", 64'(err_proto), 64'd1);
`ifdef S2CIF_ARB_TIMEOUT_EN
        begin
            int n;
            req_valid = 4'b0100;
            #1 chk("to_ready", 64'(req_ready), 64'h4);
            @(negedge clk); req_valid = '0;
            @(negedge clk);
            exp_acc++;
            n = 0;
            while (n < 40 && rsp_valid == '0) begin
                @(negedge clk); #1;
                n++;
            end
            chk("to_cycles", 64'(n), 64'd16);
            chk("to_ret", 64'({rsp_valid, rsp_ret, rsp_rdata[15:0]}), {12'h4, 32'h8000_0000, 16'h0});
            chk("to_flag", 64'(err_timeout), 64'd1);
            @(negedge clk);
        end
`else
        chk("to_off", 64'(err_timeout), 64'd0);
`endif
        chk("accepts", 64'(n_acc), 64'(exp_acc));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
